// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: registered BCD/hex to 7-segment decoder with dp, lamp test and blank codes
module seven_segment_decoder #(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit HEX_MODE   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] num,
    input  logic       dp,
    input  logic       lamp_test,
    output logic [7:0] digit_show
);
    logic [7:0] seg_al;
    logic [7:0] digit_show_d;
    logic [7:0] digit_show_q;

    // Build the active-low pattern, overlay dp and lamp test, then match board polarity
    always_comb begin
        seg_al = 8'hFF;
        case (num)
            4'd0:    seg_al = 8'hC0;
            4'd1:    seg_al = 8'hF9;
            4'd2:    seg_al = 8'hA4;
            4'd3:    seg_al = 8'hB0;
            4'd4:    seg_al = 8'h99;
            4'd5:    seg_al = 8'h92;
            4'd6:    seg_al = 8'h82;
            4'd7:    seg_al = 8'hF8;
            4'd8:    seg_al = 8'h80;
            4'd9:    seg_al = 8'h90;
            4'd10:   seg_al = HEX_MODE ? 8'h88 : 8'hFF;
            4'd11:   seg_al = HEX_MODE ? 8'h83 : 8'hBF;
            4'd12:   seg_al = HEX_MODE ? 8'hC6 : 8'hFF;
            4'd13:   seg_al = HEX_MODE ? 8'hA1 : 8'hFF;
            4'd14:   seg_al = HEX_MODE ? 8'h86 : 8'hFF;
            4'd15:   seg_al = HEX_MODE ? 8'h8E : 8'hFF;
            default: seg_al = 8'hFF;
        endcase
        if (dp)
            seg_al[7] = 1'b0;
        if (lamp_test)
            seg_al = 8'h00;
        digit_show_d = ACTIVE_LOW ? seg_al : ~seg_al;
    end

    // Output register; reset blanks the display regardless of lamp test or dp
    always_ff @(posedge clk) begin
        digit_show_q <= !rst_n ? {8{ACTIVE_LOW}} : digit_show_d;
    end

    assign digit_show = digit_show_q;
endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb_seven_segment_decoder: directed checks of decode, special codes, polarity and latency
module tb_seven_segment_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] num = 4'd0;
    logic       dp = 1'b0;
    logic       lamp_test = 1'b0;
    logic [7:0] dec_show;
    logic [7:0] hex_show;
    logic [7:0] pos_show;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    seven_segment_decoder #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) u_dec (
        .clk(clk), .rst_n(rst_n), .num(num), .dp(dp), .lamp_test(lamp_test), .digit_show(dec_show)
    );
    seven_segment_decoder #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) u_hex (
        .clk(clk), .rst_n(rst_n), .num(num), .dp(dp), .lamp_test(lamp_test), .digit_show(hex_show)
    );
    seven_segment_decoder #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) u_pos (
        .clk(clk), .rst_n(rst_n), .num(num), .dp(dp), .lamp_test(lamp_test), .digit_show(pos_show)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; num = 4'd8; lamp_test = 1'b1; dp = 1'b1;
        tick();
        tests++;
        if (dec_show !== 8'hFF) begin fails++; $display("FAIL reset_dec got %h want ff", dec_show); end
        tests++;
        if (hex_show !== 8'hFF) begin fails++; $display("FAIL reset_hex got %h want ff", hex_show); end
        tests++;
        if (pos_show !== 8'h00) begin fails++; $display("FAIL reset_pos got %h want 00", pos_show); end
        rst_n = 1'b1;
        tick();
        tests++;
        if (dec_show !== 8'h00) begin fails++; $display("FAIL release_lamp_dec got %h want 00", dec_show); end
        tests++;
        if (pos_show !== 8'hFF) begin fails++; $display("FAIL release_lamp_pos got %h want ff", pos_show); end
        lamp_test = 1'b0; dp = 1'b0;
    endtask

    task automatic test_digits;
        logic [7:0] e [0:9];
        e = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        for (int i = 0; i < 10; i++) begin
            num = 4'(i);
            tick();
            tests++;
            if (dec_show !== e[i]) begin fails++; $display("FAIL digit_%0d got %h want %h", i, dec_show, e[i]); end
            tests++;
            if (hex_show !== e[i]) begin fails++; $display("FAIL hexdigit_%0d got %h want %h", i, hex_show, e[i]); end
        end
    endtask

    task automatic test_special;
        logic [7:0] e [0:5];
        e = '{8'hFF, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int i = 0; i < 6; i++) begin
            num = 4'(10 + i);
            tick();
            tests++;
            if (dec_show !== e[i]) begin fails++; $display("FAIL special_%0d got %h want %h", 10 + i, dec_show, e[i]); end
        end
        num = 4'd10; dp = 1'b1;
        tick();
        tests++;
        if (dec_show !== 8'h7F) begin fails++; $display("FAIL blank_dp got %h want 7f", dec_show); end
        dp = 1'b0;
    endtask

    task automatic test_hex;
        logic [7:0] e [0:5];
        e = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        for (int i = 0; i < 6; i++) begin
            num = 4'(10 + i);
            tick();
            tests++;
            if (hex_show !== e[i]) begin fails++; $display("FAIL hex_%0d got %h want %h", 10 + i, hex_show, e[i]); end
        end
        num = 4'd0; dp = 1'b1;
        tick();
        tests++;
        if (hex_show !== 8'h40) begin fails++; $display("FAIL hex_zero_dp got %h want 40", hex_show); end
        dp = 1'b0;
    endtask

    task automatic test_active_high;
        num = 4'd1;
        tick();
        tests++;
        if (pos_show !== 8'h06) begin fails++; $display("FAIL pos_one got %h want 06", pos_show); end
        num = 4'd8; dp = 1'b1;
        tick();
        tests++;
        if (pos_show !== 8'hFF) begin fails++; $display("FAIL pos_eight_dp got %h want ff", pos_show); end
        num = 4'd11; dp = 1'b0;
        tick();
        tests++;
        if (pos_show !== 8'h40) begin fails++; $display("FAIL pos_dash got %h want 40", pos_show); end
        lamp_test = 1'b1;
        tick();
        tests++;
        if (pos_show !== 8'hFF) begin fails++; $display("FAIL pos_lamp got %h want ff", pos_show); end
        tests++;
        if (dec_show !== 8'h00) begin fails++; $display("FAIL dec_lamp got %h want 00", dec_show); end
        lamp_test = 1'b0;
        rst_n = 1'b0;
        tick();
        tests++;
        if (pos_show !== 8'h00) begin fails++; $display("FAIL pos_reset got %h want 00", pos_show); end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        num = 4'd3;
        @(posedge clk);
        #1;
        tests++;
        if (dec_show !== 8'hB0) begin fails++; $display("FAIL b2b_first got %h want b0", dec_show); end
        num = 4'd7;
        @(posedge clk);
        #1;
        tests++;
        if (dec_show !== 8'hF8) begin fails++; $display("FAIL b2b_second got %h want f8", dec_show); end
        num = 4'd5;
        #3;
        tests++;
        if (dec_show !== 8'hF8) begin fails++; $display("FAIL hold_between_edges got %h want f8", dec_show); end
        tick();
        tests++;
        if (dec_show !== 8'h92) begin fails++; $display("FAIL b2b_third got %h want 92", dec_show); end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_special();
        test_hex();
        test_active_high();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
